// File: rtl/dc_vlc_encoder.sv
// dc_vlc_encoder: exp-Golomb entropy coder for the quantized DC values of one
// slice. The first DC is coded directly with order 5; every later DC is coded
// as a sign-predicted delta whose order adapts to the previous delta's size.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | run enable low (or just raised); counter, flip, prev_u clear
// S_FIRST | waiting for the first DC of the slice
// S_REST  | coding later DCs as predicted deltas
// S_DONE  | slice complete; dc_valid ignored until run enable drops
//
// Pipeline: stage 1 holds (v, k) for an accepted DC, stage 2 holds the
// codeword/length, so code_valid follows dc_valid by two cycles.

module dc_vlc_encoder #(
    parameter int DC_W = 12
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   dc_vlc_reset,
    input  logic [31:0]            block_num,
    input  logic signed [DC_W-1:0] dc_in,
    input  logic                   dc_valid,
    output logic [31:0]            code_word,
    output logic [5:0]             code_len,
    output logic                   code_valid,
    output logic                   done
);

    // v carries a delta of two DC_W values, u is the folded magnitude of v,
    // x = u + 2^k needs one more bit for the order offset.
    localparam int VW = DC_W + 1;
    localparam int UW = VW + 1;
    localparam int XW = UW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_REST,
        S_DONE
    } state_t;

    state_t                 state;
    logic [31:0]            block_num_q;
    logic [31:0]            blk_cnt;
    logic signed [DC_W-1:0] prev_dc;
    logic                   flip;
    logic [UW-1:0]          prev_u;

    logic                   s1_valid;
    logic                   s1_last;
    logic signed [VW-1:0]   s1_v;
    logic [2:0]             s1_k;

    logic signed [VW-1:0]   dc_ext;
    logic signed [VW-1:0]   prev_ext;
    logic signed [VW-1:0]   delta;
    logic signed [VW-1:0]   v_rest;
    logic [UW-1:0]          u_rest;
    logic [2:0]             k_rest;
    logic [31:0]            cnt_next;
    logic                   start_zero;

    logic [UW-1:0]          u_s2;
    logic [XW-1:0]          x_s2;
    logic [5:0]             n_s2;
    logic [5:0]             len_s2;

    // Signed-to-unsigned fold: non-negative v -> 2v, negative v -> -2v-1.
    // For negative v, -2v-1 is the bitwise complement of 2v.
    function automatic logic [UW-1:0] map_u(input logic signed [VW-1:0] v);
        logic [UW-1:0] twice;
        twice = {v, 1'b0};
        return v[VW-1] ? ~twice : twice;
    endfunction

    // Adaptive order from the previous delta's folded value.
    function automatic logic [2:0] k_from_u(input logic [UW-1:0] pu);
        logic [2:0] k;
        if (pu == '0)
            k = 3'd0;
        else if (pu <= UW'(2))
            k = 3'd1;
        else if (pu <= UW'(6))
            k = 3'd2;
        else
            k = 3'd3;
        return k;
    endfunction

    // Stage-0 datapath: predicted delta, its fold and the order to use.
    always_comb begin
        dc_ext     = {dc_in[DC_W-1], dc_in};
        prev_ext   = {prev_dc[DC_W-1], prev_dc};
        delta      = dc_ext - prev_ext;
        v_rest     = flip ? -delta : delta;
        u_rest     = map_u(v_rest);
        // The second DC has no previous delta to adapt from.
        if (blk_cnt == 32'd1)
            k_rest = 3'd2;
        else
            k_rest = k_from_u(prev_u);
        cnt_next   = blk_cnt + 32'd1;
        start_zero = (state == S_IDLE) && dc_vlc_reset && (block_num == 32'd0);
    end

    // Slice FSM plus stage-1 register of (v, k) for each accepted DC.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            block_num_q <= '0;
            blk_cnt     <= '0;
            prev_dc     <= '0;
            flip        <= 1'b0;
            prev_u      <= '0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_v        <= '0;
            s1_k        <= '0;
        end else begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            if (!dc_vlc_reset) begin
                state   <= S_IDLE;
                blk_cnt <= '0;
                flip    <= 1'b0;
                prev_u  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        block_num_q <= block_num;
                        blk_cnt     <= '0;
                        state       <= (block_num == 32'd0) ? S_DONE : S_FIRST;
                    end
                    S_FIRST: begin
                        if (dc_valid) begin
                            s1_valid <= 1'b1;
                            s1_v     <= dc_ext;
                            s1_k     <= 3'd5;
                            prev_dc  <= dc_in;
                            blk_cnt  <= 32'd1;
                            if (block_num_q == 32'd1) begin
                                s1_last <= 1'b1;
                                state   <= S_DONE;
                            end else begin
                                state   <= S_REST;
                            end
                        end
                    end
                    S_REST: begin
                        if (dc_valid) begin
                            s1_valid <= 1'b1;
                            s1_v     <= v_rest;
                            s1_k     <= k_rest;
                            prev_dc  <= dc_in;
                            flip     <= delta[VW-1];
                            prev_u   <= u_rest;
                            blk_cnt  <= cnt_next;
                            if (cnt_next == block_num_q) begin
                                s1_last <= 1'b1;
                                state   <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_DONE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Stage-2 datapath: exp-Golomb codeword is x itself, right-aligned;
    // the (n-k) leading zeros are implied by the length.
    always_comb begin
        u_s2 = map_u(s1_v);
        x_s2 = {1'b0, u_s2} + (XW'(1) << s1_k);
        n_s2 = '0;
        for (int i = 0; i < XW; i++) begin
            if (x_s2[i])
                n_s2 = 6'(i);
        end
        len_s2 = (n_s2 << 1) + 6'd1 - {3'd0, s1_k};
    end

    // Stage-2 output register; a dropped run enable flushes anything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code_word  <= '0;
            code_len   <= '0;
            code_valid <= 1'b0;
            done       <= 1'b0;
        end else if (!dc_vlc_reset) begin
            code_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            code_valid <= s1_valid;
            done       <= (s1_valid && s1_last) || start_zero;
            if (s1_valid) begin
                code_word <= 32'(x_s2);
                code_len  <= len_s2;
            end
        end
    end

endmodule
